deserializer_sipo_align: RTL and testbench

//  Receive-side counterpart of the transceiver PISO serializer: serial-in, parallel-out (SIPO).

---
 rtl/deserializer_sipo_align_pkg.sv | 17 +
 rtl/deserializer_sipo_align_if.sv | 36 +++
 rtl/deserializer_sipo_align_sipo_shreg.sv | 47 ++++
 rtl/deserializer_sipo_align.sv | 134 +++++++++++++
 tb/tb_deserializer_sipo_align.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/deserializer_sipo_align_pkg.sv
// -----------------------------------------------------------------------------
// deserializer_sipo_align_pkg
// Shared definitions for the receive-side SIPO deserializer: receiver state
// encoding, default word width and the sync pattern, which must match the one
// the TX-side sync inserter puts on the line.
// -----------------------------------------------------------------------------
package deserializer_sipo_align_pkg;

    localparam int         DEFAULT_DATA_WIDTH = 8;
    localparam logic [7:0] DEFAULT_SYNC_WORD  = 8'hBC;

    typedef enum logic [0:0] {
        RX_HUNT   = 1'b0,
        RX_LOCKED = 1'b1
    } rx_state_t;

endpackage

// File: rtl/deserializer_sipo_align_if.sv
// -----------------------------------------------------------------------------
// deserializer_sipo_align_if
// Bundles the serial input stream and the parallel valid/ready output side of
// the deserializer.
//   srl_in, srl_valid  : serial bit and its qualifier (toward the deserializer)
//   data_out           : aligned word, first received bit at [0]
//   data_valid         : data_out holds an unconsumed word
//   data_ready         : consumer accepts data_out while data_valid is high
//   locked             : word alignment acquired
//   overflow           : one-cycle pulse when a completed word was dropped
// Modports: master = line/consumer side, slave = deserializer.
// -----------------------------------------------------------------------------
interface deserializer_sipo_align_if
    import deserializer_sipo_align_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
    logic                  srl_in;
    logic                  srl_valid;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic                  data_ready;
    logic                  locked;
    logic                  overflow;

    modport master (
        output srl_in, srl_valid, data_ready,
        input  data_out, data_valid, locked, overflow
    );

    modport slave (
        input  srl_in, srl_valid, data_ready,
        output data_out, data_valid, locked, overflow
    );

endinterface

// File: rtl/deserializer_sipo_align_sipo_shreg.sv
// -----------------------------------------------------------------------------
// sipo_shreg
// WIDTH-bit serial-in shift register, LSB-first: each enabled bit enters at the
// MSB and older bits move toward [0], so after WIDTH bits the first bit
// received sits at [0] (mirror image of the TX PISO).
//   clk, rst   : clock, asynchronous active-high reset
//   en_i       : shift enable (new serial bit this cycle)
//   bit_i      : serial bit
//   par_nxt_o  : value the register takes at the coming edge; the framing
//                logic needs it to see a word on the same edge its last bit
//                arrives
// -----------------------------------------------------------------------------
module sipo_shreg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] par_nxt_o
);

    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;

    // NOTE: assign a default to every always_comb output before any branch;
    // a path that leaves it unassigned infers a latch.
    always_comb begin
        shreg_d = shreg_q;
        if (en_i) begin
            shreg_d = {bit_i, shreg_q[WIDTH-1:1]};
        end
    end

    // NOTE: state registers use non-blocking (<=) assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign par_nxt_o = shreg_d;

endmodule

// File: rtl/deserializer_sipo_align.sv
// -----------------------------------------------------------------------------
// deserializer_sipo_align
// Serial-in, parallel-out receiver with sync-word alignment. In HUNT it tests
// every new bit position against SYNC_WORD; once found it frames DATA_WIDTH-bit
// words at fixed boundaries, swallows further sync words, forwards everything
// else through a one-word valid/ready holding register, and falls back to HUNT
// after LOCK_TIMEOUT consecutive non-sync words.
//   clk    : clock, all state on the rising edge
//   rst    : asynchronous active-high reset
//   rx_if  : slave modport (srl_in/srl_valid in; data_out/data_valid/
//            data_ready/locked/overflow)
// -----------------------------------------------------------------------------
module deserializer_sipo_align
    import deserializer_sipo_align_pkg::*;
#(
    parameter int                    DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] SYNC_WORD    = DATA_WIDTH'(DEFAULT_SYNC_WORD),
    parameter int                    LOCK_TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    deserializer_sipo_align_if.slave  rx_if
);

    localparam int BW = $clog2(DATA_WIDTH);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);

    localparam logic [0:0]    HUNT     = RX_HUNT;
    localparam logic [0:0]    LOCKED   = RX_LOCKED;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] TO_MAX   = TW'(LOCK_TIMEOUT);

    logic [DATA_WIDTH-1:0] shreg_nxt;

    logic [0:0]            state_q,   state_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [TW-1:0]         to_cnt_q,  to_cnt_d;
    logic [DATA_WIDTH-1:0] data_q,    data_d;
    logic                  valid_q,   valid_d;
    logic                  ovf_q,     ovf_d;

    logic                  word_fwd;
    logic                  accept;

    sipo_shreg #(
        .WIDTH (DATA_WIDTH)
    ) u_shreg (
        .clk       (clk),
        .rst       (rst),
        .en_i      (rx_if.srl_valid),
        .bit_i     (rx_if.srl_in),
        .par_nxt_o (shreg_nxt)
    );

    assign accept = valid_q & rx_if.data_ready;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        to_cnt_d  = to_cnt_q;
        data_d    = data_q;
        valid_d   = valid_q;
        ovf_d     = 1'b0;
        word_fwd  = 1'b0;

        // Framing only advances on qualified bits; idle cycles freeze it.
        if (rx_if.srl_valid) begin
            if (state_q == HUNT) begin
                if (shreg_nxt == SYNC_WORD) begin
                    state_d   = LOCKED;
                    bit_cnt_d = '0;
                    to_cnt_d  = '0;
                end
            end else begin
                if (bit_cnt_q == LAST_BIT) begin
                    bit_cnt_d = '0;
                    if (shreg_nxt == SYNC_WORD) begin
                        to_cnt_d = '0;
                    end else begin
                        word_fwd = 1'b1;
                        if (to_cnt_q != TO_MAX) begin
                            to_cnt_d = to_cnt_q + 1'b1;
                        end
                        // This word makes LOCK_TIMEOUT in a row: still
                        // forwarded, but alignment is considered lost.
                        if (to_cnt_q >= TO_LAST) begin
                            state_d = HUNT;
                        end
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
        end

        // Holding register: a word entering the same cycle the old one leaves
        // keeps data_valid high; with no room the new word is dropped.
        if (word_fwd) begin
            if (!valid_q || accept) begin
                data_d  = shreg_nxt;
                valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (accept) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= HUNT;
            bit_cnt_q <= '0;
            to_cnt_q  <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            to_cnt_q  <= to_cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ovf_q     <= ovf_d;
        end
    end

    assign rx_if.data_out   = data_q;
    assign rx_if.data_valid = valid_q;
    assign rx_if.locked     = (state_q == LOCKED);
    assign rx_if.overflow   = ovf_q;

endmodule

// File: tb/tb_deserializer_sipo_align.sv
// -----------------------------------------------------------------------------
// tb_deserializer_sipo_align
// Self-checking bench: a table of short framed streams, hand-written sequences
// for latency, backpressure/overflow, lock timeout and async reset, and
// randomized streams compared with a bit-stream reference model.
// -----------------------------------------------------------------------------
module tb_deserializer_sipo_align;
    import deserializer_sipo_align_pkg::*;

    localparam int         W       = 8;
    localparam int         TIMEOUT = 16;
    localparam logic [7:0] SYNC    = 8'hBC;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    deserializer_sipo_align_if #(.DATA_WIDTH(W)) rx_if ();

    deserializer_sipo_align #(
        .DATA_WIDTH   (W),
        .SYNC_WORD    (SYNC),
        .LOCK_TIMEOUT (TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .rx_if (rx_if)
    );

    int         errors = 0;
    int         checks = 0;
    bit         sent_bits[$];
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    int         ovf_cnt = 0;

    // Record every handshake transfer and overflow pulse, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_if.data_valid && rx_if.data_ready) rx_q.push_back(rx_if.data_out);
            if (rx_if.overflow) ovf_cnt++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: walk the received bit stream applying the alignment
    // rules directly. Fills exp_q with forwarded words, returns final lock.
    function automatic bit model_run();
        int win = 0;
        bit lk  = 1'b0;
        int cnt = 0;
        int to  = 0;
        exp_q.delete();
        foreach (sent_bits[i]) begin
            win = (win >> 1) | (int'(sent_bits[i]) << 7);
            if (!lk) begin
                if (win == int'(SYNC)) begin
                    lk  = 1'b1;
                    cnt = 0;
                    to  = 0;
                end
            end else begin
                cnt++;
                if (cnt == W) begin
                    cnt = 0;
                    if (win == int'(SYNC)) begin
                        to = 0;
                    end else begin
                        exp_q.push_back(8'(win));
                        to++;
                        if (to >= TIMEOUT) lk = 1'b0;
                    end
                end
            end
        end
        return lk;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input bit b, input int gap);
        rx_if.srl_valid = 1'b0;
        repeat (gap) tick();
        rx_if.srl_in    = b;
        rx_if.srl_valid = 1'b1;
        sent_bits.push_back(b);
        tick();
        rx_if.srl_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v, input int maxgap);
        for (int i = 0; i < 8; i++) begin
            send_bit(v[i], (maxgap == 0) ? 0 : int'($urandom_range(maxgap, 0)));
        end
    endtask

    task automatic do_reset();
        rx_if.srl_valid  = 1'b0;
        rx_if.srl_in     = 1'b0;
        rx_if.data_ready = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        sent_bits.delete();
        rx_q.delete();
        ovf_cnt = 0;
        rst = 1'b0;
        tick();
    endtask

    task automatic compare_stream(input string name);
        check({name, "_count"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s_word%0d", name, i), rx_q[i], exp_q[i]);
        end
    endtask

    typedef struct {
        string      name;
        int         npre;
        logic [2:0] pre;
        int         nbytes;
        logic [7:0] bytes [4];
        int         exp_cnt;
        logic [7:0] exp_first;
        logic [7:0] exp_last;
        bit         exp_locked;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [7:0] v;
        bit         lk;

        vecs[0] = '{"sync_5a",       0, 3'b000, 2, '{8'hBC, 8'h5A, 8'h00, 8'h00}, 1, 8'h5A, 8'h5A, 1'b1};
        vecs[1] = '{"pre3_sync_33",  3, 3'b101, 2, '{8'hBC, 8'h33, 8'h00, 8'h00}, 1, 8'h33, 8'h33, 1'b1};
        vecs[2] = '{"sync_consumed", 0, 3'b000, 4, '{8'hBC, 8'h5A, 8'hBC, 8'h77}, 2, 8'h5A, 8'h77, 1'b1};
        vecs[3] = '{"no_sync",       0, 3'b000, 1, '{8'h00, 8'h00, 8'h00, 8'h00}, 0, 8'h00, 8'h00, 1'b0};
        vecs[4] = '{"sync_only",     0, 3'b000, 1, '{8'hBC, 8'h00, 8'h00, 8'h00}, 0, 8'h00, 8'h00, 1'b1};
        vecs[5] = '{"unaligned_bc",  0, 3'b000, 3, '{8'hBC, 8'hC0, 8'h0B, 8'h00}, 2, 8'hC0, 8'h0B, 1'b1};

        rx_if.srl_in     = 1'b0;
        rx_if.srl_valid  = 1'b0;
        rx_if.data_ready = 1'b1;
        tick();

        // Reset state
        check("reset_data_out",   rx_if.data_out,   0);
        check("reset_data_valid", rx_if.data_valid, 0);
        check("reset_locked",     rx_if.locked,     0);
        check("reset_overflow",   rx_if.overflow,   0);

        // Table-driven streams
        for (int k = 0; k < 6; k++) begin
            do_reset();
            for (int i = 0; i < vecs[k].npre; i++) send_bit(vecs[k].pre[i], 0);
            for (int b = 0; b < vecs[k].nbytes; b++) send_byte(vecs[k].bytes[b], 0);
            tick();
            tick();
            check({vecs[k].name, "_count"}, rx_q.size(), vecs[k].exp_cnt);
            if (vecs[k].exp_cnt > 0 && rx_q.size() > 0) begin
                check({vecs[k].name, "_first"}, rx_q[0], vecs[k].exp_first);
                check({vecs[k].name, "_last"}, rx_q[rx_q.size()-1], vecs[k].exp_last);
            end
            check({vecs[k].name, "_locked"}, rx_if.locked, vecs[k].exp_locked);
            check({vecs[k].name, "_ovf"}, ovf_cnt, 0);
        end

        // Lock and output latency
        do_reset();
        v = SYNC;
        for (int i = 0; i < 7; i++) send_bit(v[i], 0);
        check("lat_locked_before", rx_if.locked, 0);
        send_bit(v[7], 0);
        check("lat_locked_after", rx_if.locked, 1);
        v = 8'h5A;
        for (int i = 0; i < 7; i++) send_bit(v[i], 0);
        check("lat_valid_before", rx_if.data_valid, 0);
        send_bit(v[7], 0);
        check("lat_valid_after", rx_if.data_valid, 1);
        check("lat_data", rx_if.data_out, 8'h5A);
        tick();
        check("lat_valid_drop", rx_if.data_valid, 0);
        check("lat_count", rx_q.size(), 1);

        // Backpressure and overflow
        do_reset();
        rx_if.data_ready = 1'b0;
        send_byte(SYNC, 0);
        send_byte(8'h11, 0);
        check("ovf_hold_valid", rx_if.data_valid, 1);
        v = 8'h22;
        for (int i = 0; i < 7; i++) send_bit(v[i], 0);
        check("ovf_pre_pulse", rx_if.overflow, 0);
        send_bit(v[7], 0);
        check("ovf_pulse", rx_if.overflow, 1);
        check("ovf_data_kept", rx_if.data_out, 8'h11);
        tick();
        check("ovf_pulse_end", rx_if.overflow, 0);
        check("ovf_pulse_count", ovf_cnt, 1);
        rx_if.data_ready = 1'b1;
        tick();
        check("ovf_drain_valid", rx_if.data_valid, 0);
        check("ovf_drain_count", rx_q.size(), 1);
        if (rx_q.size() > 0) check("ovf_drain_word", rx_q[0], 8'h11);

        // Consecutive words with ready held
        do_reset();
        send_byte(SYNC, 0);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        send_byte(8'h03, 0);
        tick();
        tick();
        lk = model_run();
        compare_stream("b2b");
        check("b2b_ovf", ovf_cnt, 0);

        // Lock timeout and relock
        do_reset();
        send_byte(SYNC, 0);
        for (int i = 1; i <= TIMEOUT; i++) begin
            send_byte(8'(i), 0);
            if (i == TIMEOUT - 1) check("to_locked_before", rx_if.locked, 1);
        end
        check("to_unlocked", rx_if.locked, 0);
        tick();
        tick();
        lk = model_run();
        compare_stream("timeout");
        check("timeout_model_lock", rx_if.locked, lk);
        send_byte(SYNC, 0);
        check("to_relocked", rx_if.locked, 1);

        // Asynchronous reset mid-word
        do_reset();
        rx_if.data_ready = 1'b0;
        send_byte(SYNC, 0);
        send_byte(8'h5A, 0);
        v = 8'h77;
        for (int i = 0; i < 4; i++) send_bit(v[i], 0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_data_out",   rx_if.data_out,   0);
        check("arst_data_valid", rx_if.data_valid, 0);
        check("arst_locked",     rx_if.locked,     0);
        check("arst_overflow",   rx_if.overflow,   0);
        tick();
        sent_bits.delete();
        rx_q.delete();
        rst = 1'b0;
        rx_if.data_ready = 1'b1;
        tick();
        for (int i = 4; i < 8; i++) send_bit(v[i], 0);
        send_byte(8'h44, 0);
        tick();
        tick();
        check("arst_no_words", rx_q.size(), 0);
        check("arst_still_hunt", rx_if.locked, 0);

        // Randomized streams against the reference model
        for (int r = 0; r < 10; r++) begin
            int npre;
            int nby;
            do_reset();
            npre = int'($urandom_range(10, 0));
            for (int i = 0; i < npre; i++) send_bit(1'($urandom), 0);
            send_byte(SYNC, 2);
            nby = int'($urandom_range(24, 4));
            for (int b = 0; b < nby; b++) begin
                if ($urandom_range(7, 0) == 0) send_byte(SYNC, 2);
                else send_byte(8'($urandom), 2);
            end
            tick();
            tick();
            lk = model_run();
            compare_stream($sformatf("rand%0d", r));
            check($sformatf("rand%0d_locked", r), rx_if.locked, lk);
            check($sformatf("rand%0d_ovf", r), ovf_cnt, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
